// File: rtl/my_and3_if.sv
// ---------------------------------------------------------------------------
// my_and3_if
//   Bundles the operand, enable and result signals of the my_and3 gate block.
//   clk and rst_n are not part of the bundle and stay plain module ports.
//
//   Parameters
//     WIDTH  bit width of a, b, x and x_q
//     CNT_W  width of the high-cycle counter hi_cnt
//
//   Signals
//     a, b    operands (driven by the master)
//     en      register enable for x_q (driven by the master)
//     x       combinational a & b
//     x_q     registered a & b, updated only while en = 1
//     x_all   registered reduction AND of (a & b)
//     x_rise  one-cycle pulse on a 0 -> 1 transition of x_all
//     hi_cnt  saturating count of cycles on which x_all was sampled as 1
//
//   Modports
//     master  drives a, b, en and observes every result
//     slave   the gate block: reads a, b, en and drives every result
// ---------------------------------------------------------------------------
interface my_and3_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] x_q;
  logic             x_all;
  logic             x_rise;
  logic [CNT_W-1:0] hi_cnt;

  modport master (
    output a, b, en,
    input  x, x_q, x_all, x_rise, hi_cnt
  );

  modport slave (
    input  a, b, en,
    output x, x_q, x_all, x_rise, hi_cnt
  );

endinterface

// File: rtl/my_and3.sv
// ---------------------------------------------------------------------------
// my_and3
//   Two-input AND gate from the basic-gates library, bit-wise over WIDTH bits,
//   with clocked companions for downstream synchronous logic.
//
//   Ports
//     clk    system clock, rising-edge active
//     rst_n  asynchronous active-low reset; clears every registered output
//     bus    my_and3_if.slave
//              a, b, en        inputs
//              x               combinational a & b (independent of clk/rst_n)
//              x_q             registered a & b, held while en = 0
//              x_all           registered &(a & b), sampled every edge
//              x_rise          one-cycle pulse when x_all goes 0 -> 1
//              hi_cnt          saturating count of edges with &(a & b) = 1
// ---------------------------------------------------------------------------
module my_and3 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  my_and3_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] and_w;
  logic             and_all_w;

  logic [WIDTH-1:0] and_d,  and_q;
  logic             all_d,  all_q;
  logic             rise_d, rise_q;
  logic [CNT_W-1:0] cnt_d,  cnt_q;

  // The combinational result never touches the clock or reset, so x stays
  // correct with clk stopped and rst_n held in either state.
  assign and_w     = bus.a & bus.b;
  assign and_all_w = &and_w;
  assign bus.x     = and_w;

  // all_q doubles as the previous-state flag for the rise detector: it still
  // holds the last sample when the new sample is compared against it.
  always_comb begin
    and_d  = and_q;
    all_d  = and_all_w;
    rise_d = and_all_w & ~all_q;
    cnt_d  = cnt_q;
    if (bus.en) begin
      and_d = and_w;
    end
    if (and_all_w && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_q  <= '0;
      all_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      and_q  <= and_d;
      all_q  <= all_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.x_q    = and_q;
  assign bus.x_all  = all_q;
  assign bus.x_rise = rise_q;
  assign bus.hi_cnt = cnt_q;

endmodule

// File: tb/tb_my_and3.sv
// ---------------------------------------------------------------------------
// tb_my_and3
//   Directed bench for my_and3. Three instances share clk and rst_n:
//     u_w1   WIDTH = 1, CNT_W = 8  (main function, pulse, reset)
//     u_sat  WIDTH = 1, CNT_W = 3  (counter saturation)
//     u_w4   WIDTH = 4, CNT_W = 8  (bit-wise and reduction behaviour)
//   Inputs change on the falling edge; registered outputs are read 1 ns
//   after the rising edge.
// ---------------------------------------------------------------------------
module tb_my_and3;

  logic clk;
  logic rst_n;
  bit   clk_run;

  int checks;
  int errors;

  my_and3_if #(.WIDTH(1), .CNT_W(8)) if_w1 ();
  my_and3_if #(.WIDTH(1), .CNT_W(3)) if_sat ();
  my_and3_if #(.WIDTH(4), .CNT_W(8)) if_w4 ();

  my_and3 #(.WIDTH(1), .CNT_W(8)) u_w1  (.clk(clk), .rst_n(rst_n), .bus(if_w1));
  my_and3 #(.WIDTH(1), .CNT_W(3)) u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat));
  my_and3 #(.WIDTH(4), .CNT_W(8)) u_w4  (.clk(clk), .rst_n(rst_n), .bus(if_w4));

  // The clock only toggles once clk_run is set, so the combinational sweep
  // can run with no clock activity at all.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_w1.x_q !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_x_q: got %0h expected 0", if_w1.x_q);
    end
    checks++;
    if (if_w1.x_all !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_x_all: got %0h expected 0", if_w1.x_all);
    end
    checks++;
    if (if_w1.x_rise !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_x_rise: got %0h expected 0", if_w1.x_rise);
    end
    checks++;
    if (if_w1.hi_cnt !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_hi_cnt: got %0d expected 0", if_w1.hi_cnt);
    end
    checks++;
    if (if_w4.x_q !== 4'h0) begin
      errors++; $display("[TB] FAIL reset_w4_x_q: got %0h expected 0", if_w4.x_q);
    end
  endtask

  task automatic test_comb();
    logic [1:0] vec [4];
    logic       exp [4];
    vec[0] = 2'b00; exp[0] = 1'b0;
    vec[1] = 2'b10; exp[1] = 1'b0;
    vec[2] = 2'b01; exp[2] = 1'b0;
    vec[3] = 2'b11; exp[3] = 1'b1;
    // x must follow the inputs even while reset is held.
    if_w1.a = 1'b1; if_w1.b = 1'b1;
    #100;
    checks++;
    if (if_w1.x !== 1'b1) begin
      errors++; $display("[TB] FAIL comb_in_reset: got %0h expected 1", if_w1.x);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_w1.a = vec[i][1];
      if_w1.b = vec[i][0];
      #100;
      checks++;
      if (if_w1.x !== exp[i]) begin
        errors++;
        $display("[TB] FAIL comb_a%0h_b%0h: got %0h expected %0h",
                 vec[i][1], vec[i][0], if_w1.x, exp[i]);
      end
    end
    if_w1.a = 1'b0; if_w1.b = 1'b0;
  endtask

  task automatic test_registered();
    do_reset();
    @(negedge clk);
    if_w1.a = 1'b1; if_w1.b = 1'b1; if_w1.en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if_w1.x_q !== 1'b1) begin
      errors++; $display("[TB] FAIL reg_x_q_capture: got %0h expected 1", if_w1.x_q);
    end
    checks++;
    if (if_w1.x_all !== 1'b1) begin
      errors++; $display("[TB] FAIL reg_x_all_capture: got %0h expected 1", if_w1.x_all);
    end
    @(negedge clk);
    if_w1.en = 1'b0; if_w1.a = 1'b0;
    #1;
    checks++;
    if (if_w1.x !== 1'b0) begin
      errors++; $display("[TB] FAIL reg_x_immediate: got %0h expected 0", if_w1.x);
    end
    @(posedge clk); #1;
    checks++;
    if (if_w1.x_q !== 1'b1) begin
      errors++; $display("[TB] FAIL reg_x_q_hold: got %0h expected 1", if_w1.x_q);
    end
    checks++;
    if (if_w1.x_all !== 1'b0) begin
      errors++; $display("[TB] FAIL reg_x_all_drop: got %0h expected 0", if_w1.x_all);
    end
    @(negedge clk);
    if_w1.en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if_w1.x_q !== 1'b0) begin
      errors++; $display("[TB] FAIL reg_x_q_reenable: got %0h expected 0", if_w1.x_q);
    end
  endtask

  task automatic test_edge_pulse();
    do_reset();
    @(negedge clk);
    if_w1.a = 1'b0; if_w1.b = 1'b0; if_w1.en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    if_w1.a = 1'b1; if_w1.b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (if_w1.x_rise !== (i == 0)) begin
        errors++;
        $display("[TB] FAIL pulse_rise_cycle%0d: got %0h expected %0h",
                 i, if_w1.x_rise, (i == 0));
      end
      checks++;
      if (if_w1.hi_cnt !== 8'(i + 1)) begin
        errors++;
        $display("[TB] FAIL pulse_cnt_cycle%0d: got %0d expected %0d",
                 i, if_w1.hi_cnt, i + 1);
      end
    end
    @(negedge clk);
    if_w1.b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (if_w1.x_rise !== 1'b0) begin
        errors++; $display("[TB] FAIL pulse_rise_low%0d: got %0h expected 0", i, if_w1.x_rise);
      end
      checks++;
      if (if_w1.hi_cnt !== 8'd5) begin
        errors++; $display("[TB] FAIL pulse_cnt_hold%0d: got %0d expected 5", i, if_w1.hi_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    @(negedge clk);
    if_sat.a = 1'b1; if_sat.b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      exp = (i + 1 > 7) ? 7 : i + 1;
      checks++;
      if (if_sat.hi_cnt !== 3'(exp)) begin
        errors++;
        $display("[TB] FAIL sat_cnt_cycle%0d: got %0d expected %0d", i, if_sat.hi_cnt, exp);
      end
    end
    @(negedge clk);
    if_sat.a = 1'b0; if_sat.b = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    if_w1.a = 1'b1; if_w1.b = 1'b1; if_w1.en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (if_w1.x_q !== 1'b1 || if_w1.hi_cnt !== 8'd4) begin
      errors++;
      $display("[TB] FAIL arst_prior_state: got x_q=%0h hi_cnt=%0d expected x_q=1 hi_cnt=4",
               if_w1.x_q, if_w1.hi_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_w1.x_q !== 1'b0 || if_w1.x_all !== 1'b0 ||
        if_w1.x_rise !== 1'b0 || if_w1.hi_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL arst_clear: got x_q=%0h x_all=%0h x_rise=%0h hi_cnt=%0d expected all 0",
               if_w1.x_q, if_w1.x_all, if_w1.x_rise, if_w1.hi_cnt);
    end
    checks++;
    if (if_w1.x !== 1'b1) begin
      errors++; $display("[TB] FAIL arst_x_live: got %0h expected 1", if_w1.x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if_w1.x_all !== 1'b1 || if_w1.x_rise !== 1'b1) begin
      errors++;
      $display("[TB] FAIL arst_release_pulse: got x_all=%0h x_rise=%0h expected 1 1",
               if_w1.x_all, if_w1.x_rise);
    end
    checks++;
    if (if_w1.hi_cnt !== 8'd1) begin
      errors++; $display("[TB] FAIL arst_release_cnt: got %0d expected 1", if_w1.hi_cnt);
    end
  endtask

  task automatic test_width4();
    do_reset();
    @(negedge clk);
    if_w4.a = 4'b1011; if_w4.b = 4'b1101; if_w4.en = 1'b1;
    #1;
    checks++;
    if (if_w4.x !== 4'b1001) begin
      errors++; $display("[TB] FAIL w4_x_partial: got %0h expected 9", if_w4.x);
    end
    @(posedge clk); #1;
    checks++;
    if (if_w4.x_all !== 1'b0 || if_w4.x_q !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL w4_reg_partial: got x_all=%0h x_q=%0h expected x_all=0 x_q=9",
               if_w4.x_all, if_w4.x_q);
    end
    @(negedge clk);
    if_w4.a = 4'hF; if_w4.b = 4'hF;
    #1;
    checks++;
    if (if_w4.x !== 4'hF) begin
      errors++; $display("[TB] FAIL w4_x_full: got %0h expected f", if_w4.x);
    end
    @(posedge clk); #1;
    checks++;
    if (if_w4.x_all !== 1'b1 || if_w4.x_q !== 4'hF || if_w4.x_rise !== 1'b1) begin
      errors++;
      $display("[TB] FAIL w4_reg_full: got x_all=%0h x_q=%0h x_rise=%0h expected 1 f 1",
               if_w4.x_all, if_w4.x_q, if_w4.x_rise);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clk_run = 1'b0;
    rst_n   = 1'b1;
    if_w1.a  = 1'b0; if_w1.b  = 1'b0; if_w1.en  = 1'b1;
    if_sat.a = 1'b0; if_sat.b = 1'b0; if_sat.en = 1'b1;
    if_w4.a  = 4'h0; if_w4.b  = 4'h0; if_w4.en  = 1'b1;

    test_reset();
    test_comb();
    clk_run = 1'b1;
    test_registered();
    test_edge_pulse();
    test_saturation();
    test_async_reset();
    test_width4();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_and3.md
Name: my_and3

Overview:
- Two-input AND gate block from the basic-gates library.
- Combinational output x = a & b, bit-wise over a parameterised width; default width is 1 bit, a plain 2-input AND.
- Adds clocked companions for downstream synchronous logic: a registered copy of x, a reduction flag, a rising-edge pulse and a saturating high-cycle counter.
- Sits at leaf level; instantiated directly by higher-level gate/logic exercises and their benches.

Parameters:
- WIDTH, 1, bit width of a, b, x and x_q.
- CNT_W, 8, width of the high-cycle counter hi_cnt.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- en  input  1  register enable for x_q; tie high for free-running.
- x  output  WIDTH  combinational a & b.
- x_q  output  WIDTH  registered a & b.
- x_all  output  1  registered reduction: 1 when every bit of (a & b) is 1.
- x_rise  output  1  one-cycle pulse when x_all goes 0 -> 1.
- hi_cnt  output  CNT_W  saturating count of cycles with x_all = 1.

Behaviour:
- x is purely combinational, bit-wise a[i] & b[i].
  - No clock dependence.
  - Valid within gate delay of any input change.
  - Unaffected by rst_n; x must be correct even with clk not toggling and rst_n held in either state.
- Truth table per bit: 00 -> 0, 10 -> 0, 01 -> 0, 11 -> 1.
- X/Z handling: any bit with a 0 on either input yields 0. Other X/Z combinations propagate X in simulation; no special handling.
- Asynchronous reset (rst_n = 0), effective immediately regardless of clk:
  - x_q = 0, x_all = 0, x_rise = 0, hi_cnt = 0.
  - Internal previous-state flag for x_all = 0.
- Reset release is synchronous in effect: first update occurs on the first rising clk edge after rst_n = 1.
- x_q, on each rising clk edge out of reset:
  - en = 1: x_q <= a & b.
  - en = 0: x_q holds.
  - Latency one cycle.
- x_all <= &(a & b) every rising edge, independent of en. Latency one cycle. For WIDTH = 1, x_all equals x delayed one cycle.
- x_rise: asserted for exactly one cycle, on the cycle x_all first reads 1 after reading 0. Implement as registered x_all & ~previous x_all.
  - Held high across consecutive cycles only never; a sustained 1 produces a single pulse.
  - Reset clears the previous flag, so x_all = 1 on the first post-reset sample produces a pulse.
- hi_cnt increments by 1 on each edge where the newly sampled &(a & b) = 1.
  - Saturates at 2^CNT_W - 1; no wrap.
  - Holds when input AND is 0.
  - Cleared only by reset.
- Reset asserted mid-operation:
  - All registered outputs go to 0 immediately.
  - x continues to follow a & b.
- Simultaneous input change and clock edge: registered outputs capture the value stable at the edge. Setup is the integrator's responsibility; no synchroniser is included.
- No handshakes, no back-pressure; every output is valid every cycle.

Test Plan:
- Combinational sweep, WIDTH = 1, en = 1, rst_n = 1, 100 ns per step:
  - a=0,b=0 -> x=0
  - a=1,b=0 -> x=0
  - a=0,b=1 -> x=0
  - a=1,b=1 -> x=1
  - Check x settled before each next step, with no clock running.
- Registered path: a=b=1 sampled at edge N -> x_q=1 and x_all=1 after edge N. Then en=0 and a=0 -> x=0 immediately, x_q stays 1, x_all=0 after the next edge.
- Edge pulse: from a=b=0, drive a=b=1 for 5 cycles -> x_rise=1 for exactly one cycle and hi_cnt=5. Drop b to 0 -> x_rise stays 0 and hi_cnt holds 5.
- Saturation: CNT_W=3, hold a=b=1 for 10 cycles -> hi_cnt reaches 7 and stays 7.
- Async reset mid-run: with x_q=1 and hi_cnt=4, pull rst_n low between clock edges -> x_q, x_all, x_rise, hi_cnt = 0 immediately, while x still equals 1 for a=b=1. Release rst_n -> first edge gives x_all=1 and x_rise=1.
- WIDTH=4: a=4'b1011, b=4'b1101 -> x=4'b1001 and x_all=0. Then a=b=4'hF -> x=4'hF and x_all=1 after one edge.
